// File: rtl/muldiv_iter_if.sv
// Request/response bundle between the execute stage and the iterative
// multiply/divide unit. The master is the requester; the slave is the unit.
interface muldiv_iter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             kill;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             busy;

    modport master (
        output in_valid, op, a, b, kill, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, a, b, kill, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative RV32M-style multiply/divide unit.
// One radix-2 step per cycle on magnitudes: shift-add multiply, restoring
// divide. Signs and the divide special cases are resolved in a single FIX
// cycle, so latency is the same for every op and operand pair.
module muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_iter_if.slave  bus
);
    localparam int unsigned      CNTW = $clog2(WIDTH) + 1;
    localparam logic [CNTW-1:0]  LAST = CNTW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a_raw;
    logic [WIDTH-1:0]   r_a_mag;
    logic [WIDTH-1:0]   r_b_mag;
    logic               r_neg_a;
    logic               r_neg_b;
    logic               r_b_zero;
    logic               r_ovf;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNTW-1:0]    r_cnt;
    logic [WIDTH-1:0]   r_result;

    logic               w_accept;
    logic               w_sgn_a;
    logic               w_sgn_b;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;

    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_step;
    logic [WIDTH+1:0]   w_div_try;
    logic               w_div_ok;
    logic [2*WIDTH-1:0] w_div_step;

    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fix_result;

    assign w_accept = (r_state == IDLE) && bus.in_valid && !bus.kill;

    // Operand signedness decode for the op being offered in IDLE.
    always_comb begin
        w_sgn_a = 1'b0;
        w_sgn_b = 1'b0;
        case (bus.op)
            OP_MULH:   begin w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
            OP_MULHSU: begin w_sgn_a = 1'b1; end
            OP_DIV:    begin w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
            OP_REM:    begin w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
            default:   begin end
        endcase
    end

    assign w_neg_a = w_sgn_a && bus.a[WIDTH-1];
    assign w_neg_b = w_sgn_b && bus.b[WIDTH-1];
    assign w_mag_a = w_neg_a ? -bus.a : bus.a;
    assign w_mag_b = w_neg_b ? -bus.b : bus.b;

    // Shift-add step: acc = {partial product, remaining multiplier bits}.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_a_mag} : '0);
    assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring step: acc = {partial remainder, dividend/quotient bits}.
    assign w_div_try  = {1'b0, r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]}
                      - {2'b00, r_b_mag};
    assign w_div_ok   = !w_div_try[WIDTH+1];
    assign w_div_step = w_div_ok ? {w_div_try[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                                 : {r_acc[2*WIDTH-2:0], 1'b0};

    // Sign correction, divide special cases and result selection for FIX.
    always_comb begin
        w_prod = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;

        if (r_b_zero) begin
            w_quot = '1;
            w_rem  = r_a_raw;
        end else if (r_ovf) begin
            w_quot = r_a_raw;
            w_rem  = '0;
        end else begin
            w_quot = (r_neg_a ^ r_neg_b) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
            w_rem  = r_neg_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        end

        w_fix_result = '0;
        case (r_op)
            OP_MUL:                      w_fix_result = w_prod[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix_result = w_prod[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:             w_fix_result = w_quot;
            OP_REM, OP_REMU:             w_fix_result = w_rem;
            default:                     w_fix_result = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; kill wins over every other transition outside IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = CALC;
            CALC: begin
                if (bus.kill)           w_next = IDLE;
                else if (r_cnt == LAST) w_next = FIX;
            end
            FIX:  w_next = bus.kill ? IDLE : DONE;
            DONE: begin
                if (bus.kill || bus.out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Datapath: operand capture on accept, one step per CALC cycle, result load in FIX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= '0;
            r_a_raw  <= '0;
            r_a_mag  <= '0;
            r_b_mag  <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_b_zero <= 1'b0;
            r_ovf    <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op     <= bus.op;
                        r_a_raw  <= bus.a;
                        r_a_mag  <= w_mag_a;
                        r_b_mag  <= w_mag_b;
                        r_neg_a  <= w_neg_a;
                        r_neg_b  <= w_neg_b;
                        r_b_zero <= (bus.b == '0);
                        r_ovf    <= w_sgn_b && bus.op[2] && (bus.a == MINV) && (bus.b == '1);
                        r_acc    <= {{WIDTH{1'b0}}, (bus.op[2] ? w_mag_a : w_mag_b)};
                        r_cnt    <= '0;
                    end
                end
                CALC: begin
                    r_acc <= r_op[2] ? w_div_step : w_mul_step;
                    r_cnt <= r_cnt + 1'b1;
                end
                FIX: begin
                    if (!bus.kill) r_result <= w_fix_result;
                end
                default: begin end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.result    = r_result;
endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter at WIDTH=32 and WIDTH=8.
module tb_muldiv_iter;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    muldiv_iter_if #(.WIDTH(32)) if32 ();
    muldiv_iter_if #(.WIDTH(8))  if8 ();

    muldiv_iter #(.WIDTH(32)) u_dut32 (.clk(clk), .reset(reset), .bus(if32));
    muldiv_iter #(.WIDTH(8))  u_dut8  (.clk(clk), .reset(reset), .bus(if8));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        @(posedge clk); #1;
        if32.in_valid = 1'b1; if32.op = op; if32.a = a; if32.b = b;
        @(posedge clk); #1;
        if32.in_valid = 1'b0;
        lat = 0;
        while (!if32.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = if32.result;
        if32.out_ready = 1'b1;
        @(posedge clk); #1;
        if32.out_ready = 1'b0;
    endtask

    task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output int lat);
        @(posedge clk); #1;
        if8.in_valid = 1'b1; if8.op = op; if8.a = a; if8.b = b;
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
        lat = 0;
        while (!if8.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = if8.result;
        if8.out_ready = 1'b1;
        @(posedge clk); #1;
        if8.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        n_vec++;
        if (if32.in_ready !== 1'b1 || if32.out_valid !== 1'b0 || if32.busy !== 1'b0 || if32.result !== 32'h0) begin
            n_err++;
            $display("FAIL reset32: rdy=%b vld=%b busy=%b res=%h, want 1 0 0 0", if32.in_ready, if32.out_valid, if32.busy, if32.result);
        end
        n_vec++;
        if (if8.in_ready !== 1'b1 || if8.out_valid !== 1'b0 || if8.busy !== 1'b0 || if8.result !== 8'h0) begin
            n_err++;
            $display("FAIL reset8: rdy=%b vld=%b busy=%b res=%h, want 1 0 0 0", if8.in_ready, if8.out_valid, if8.busy, if8.result);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_mul;
        logic [2:0]  ops [4] = '{3'b000, 3'b001, 3'b011, 3'b010};
        logic [31:0] as  [4] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] bs  [4] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [4] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run32(ops[i], as[i], bs[i], res, lat);
            n_vec++;
            if (res !== exp[i]) begin
                n_err++;
                $display("FAIL mul[%0d] op=%b: got %h want %h", i, ops[i], res, exp[i]);
            end
            n_vec++;
            if (lat !== 33) begin
                n_err++;
                $display("FAIL mul_lat[%0d]: got %0d want 33", i, lat);
            end
        end
    endtask

    task automatic test_div;
        logic [2:0]  ops [8] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110};
        logic [31:0] as  [8] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] bs  [8] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 8; i++) begin
            run32(ops[i], as[i], bs[i], res, lat);
            n_vec++;
            if (res !== exp[i]) begin
                n_err++;
                $display("FAIL div[%0d] op=%b: got %h want %h", i, ops[i], res, exp[i]);
            end
            n_vec++;
            if (lat !== 33) begin
                n_err++;
                $display("FAIL div_lat[%0d]: got %0d want 33", i, lat);
            end
        end
    endtask

    task automatic test_backpressure;
        int lat;
        @(posedge clk); #1;
        if32.in_valid = 1'b1; if32.op = 3'b101; if32.a = 32'd100; if32.b = 32'd7;
        @(posedge clk); #1;
        if32.in_valid = 1'b0;
        n_vec++;
        if (if32.in_ready !== 1'b0 || if32.busy !== 1'b1) begin
            n_err++;
            $display("FAIL calc_flags: rdy=%b busy=%b want 0 1", if32.in_ready, if32.busy);
        end
        // Request offered mid-CALC must be dropped.
        @(posedge clk); #1;
        if32.in_valid = 1'b1; if32.op = 3'b000; if32.a = 32'd1; if32.b = 32'd1;
        @(posedge clk); #1;
        if32.in_valid = 1'b0;
        lat = 2;
        while (!if32.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        n_vec++;
        if (lat !== 33) begin
            n_err++;
            $display("FAIL bp_lat: got %0d want 33", lat);
        end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (if32.out_valid !== 1'b1 || if32.result !== 32'd14 || if32.in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL hold[%0d]: vld=%b res=%h rdy=%b want 1 0000000e 0", i, if32.out_valid, if32.result, if32.in_ready);
            end
            @(posedge clk); #1;
        end
        // Drain while a new request is offered: only the drain may happen.
        if32.in_valid = 1'b1; if32.op = 3'b000; if32.a = 32'd2; if32.b = 32'd2;
        if32.out_ready = 1'b1;
        @(posedge clk); #1;
        if32.in_valid = 1'b0;
        if32.out_ready = 1'b0;
        n_vec++;
        if (if32.in_ready !== 1'b1 || if32.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL drain: rdy=%b vld=%b want 1 0", if32.in_ready, if32.out_valid);
        end
        @(posedge clk); #1;
        n_vec++;
        if (if32.busy !== 1'b0) begin
            n_err++;
            $display("FAIL drain_noaccept: busy=%b want 0", if32.busy);
        end
    endtask

    task automatic test_kill;
        int seen;
        @(posedge clk); #1;
        if32.in_valid = 1'b1; if32.op = 3'b000; if32.a = 32'd5; if32.b = 32'd6;
        @(posedge clk); #1;
        if32.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        if32.kill = 1'b1;
        @(posedge clk); #1;
        if32.kill = 1'b0;
        n_vec++;
        if (if32.in_ready !== 1'b1 || if32.busy !== 1'b0 || if32.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL kill: rdy=%b busy=%b vld=%b want 1 0 0", if32.in_ready, if32.busy, if32.out_valid);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (if32.out_valid === 1'b1) seen++;
        end
        n_vec++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL kill_novalid: saw %0d valid cycles, want 0", seen);
        end
        n_vec++;
        if (if32.result !== 32'd14) begin
            n_err++;
            $display("FAIL kill_result: got %h want 0000000e", if32.result);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] res;
        int lat;
        @(posedge clk); #1;
        if32.in_valid = 1'b1; if32.op = 3'b000; if32.a = 32'd9; if32.b = 32'd9;
        @(posedge clk); #1;
        if32.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_vec++;
        if (if32.out_valid !== 1'b0 || if32.in_ready !== 1'b1 || if32.busy !== 1'b0 || if32.result !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid: vld=%b rdy=%b busy=%b res=%h want 0 1 0 0", if32.out_valid, if32.in_ready, if32.busy, if32.result);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        run32(3'b000, 32'd3, 32'd4, res, lat);
        n_vec++;
        if (res !== 32'd12) begin
            n_err++;
            $display("FAIL post_reset_mul: got %h want 0000000c", res);
        end
        n_vec++;
        if (lat !== 33) begin
            n_err++;
            $display("FAIL post_reset_lat: got %0d want 33", lat);
        end
    endtask

    task automatic test_w8;
        logic [2:0] ops [3] = '{3'b011, 3'b100, 3'b111};
        logic [7:0] as  [3] = '{8'hFF, 8'h80, 8'hC8};
        logic [7:0] bs  [3] = '{8'hFF, 8'hFF, 8'h0F};
        logic [7:0] exp [3] = '{8'hFE, 8'h80, 8'h05};
        logic [7:0] res;
        int lat;
        for (int i = 0; i < 3; i++) begin
            run8(ops[i], as[i], bs[i], res, lat);
            n_vec++;
            if (res !== exp[i]) begin
                n_err++;
                $display("FAIL w8[%0d] op=%b: got %h want %h", i, ops[i], res, exp[i]);
            end
            n_vec++;
            if (lat !== 9) begin
                n_err++;
                $display("FAIL w8_lat[%0d]: got %0d want 9", i, lat);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        if32.in_valid = 1'b0; if32.op = 3'b000; if32.a = '0; if32.b = '0;
        if32.kill = 1'b0; if32.out_ready = 1'b0;
        if8.in_valid = 1'b0; if8.op = 3'b000; if8.a = '0; if8.b = '0;
        if8.kill = 1'b0; if8.out_ready = 1'b0;

        test_reset;
        test_mul;
        test_div;
        test_backpressure;
        test_kill;
        test_reset_mid;
        test_w8;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
